// File: rtl/gat_loader_pkg.sv
// Shared types and width/depth helpers for the PS-side BRAM loader and the memory controller.
package gat_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_H,
    LOAD_NI,
    LOAD_W,
    LOAD_A,
    DONE
  } state_t;

  function automatic int h_data_width(input int data_width, input int num_feature_in);
    return data_width + $clog2(num_feature_in);
  endfunction

  function automatic int node_info_width(input int num_feature_in, input int max_nodes);
    return $clog2(num_feature_in) + $clog2(max_nodes) + 1;
  endfunction

  // A one-word memory still needs a 1-bit address port.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/loader_seg_cnt.sv
// Shared segment word counter: wraps to zero on an increment at the programmable terminal value.
module loader_seg_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] last_val,
  output logic [CNT_W-1:0] count,
  output logic             last_hit
);

  assign last_hit = (count == last_val);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last_hit ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps_bram_loader.sv
// Splits one PS DMA word stream into the H data, node_info, weight and a BRAM write ports, in that order.
module ps_bram_loader
  import gat_loader_pkg::*;
#(
  parameter  int DATA_WIDTH        = 8,
  parameter  int H_NUM_SPARSE_DATA = 242101,
  parameter  int TOTAL_NODES       = 13264,
  parameter  int NUM_FEATURE_IN    = 1433,
  parameter  int NUM_FEATURE_OUT   = 16,
  parameter  int MAX_NODES         = 168,
  localparam int H_DATA_WIDTH      = h_data_width(DATA_WIDTH, NUM_FEATURE_IN),
  localparam int NODE_INFO_WIDTH   = node_info_width(NUM_FEATURE_IN, MAX_NODES),
  localparam int W_DEPTH           = NUM_FEATURE_OUT * NUM_FEATURE_IN,
  localparam int A_DEPTH           = 2 * NUM_FEATURE_OUT,
  localparam int S_DATA_WIDTH      = max3(H_DATA_WIDTH, NODE_INFO_WIDTH, DATA_WIDTH),
  localparam int H_DATA_ADDR_W     = addr_w(H_NUM_SPARSE_DATA),
  localparam int NODE_INFO_ADDR_W  = addr_w(TOTAL_NODES),
  localparam int WEIGHT_ADDR_W     = addr_w(W_DEPTH),
  localparam int A_ADDR_W          = addr_w(A_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [S_DATA_WIDTH-1:0]     s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]       wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra,
  output logic [DATA_WIDTH-1:0]       a_bram_din,
  output logic                        a_bram_ena,
  output logic [A_ADDR_W-1:0]         a_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        a_bram_load_done,
  output logic                        busy,
  output logic                        all_done,
  output logic                        len_err
);

  localparam int CNT_W = max3(max3(H_DATA_ADDR_W, NODE_INFO_ADDR_W, WEIGHT_ADDR_W), A_ADDR_W, 1);

  state_t           state_q, state_d;
  logic [3:0]       seg_sel;
  logic [CNT_W-1:0] last_val;
  logic [CNT_W-1:0] count;
  logic             last_hit;
  logic             accept;
  logic             restart;
  logic [3:0]       last_wr_q;
  logic [3:0]       done_q;
  logic             len_err_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg_sel  = 4'b0000;
    last_val = '0;
    unique case (state_q)
      LOAD_H: begin
        seg_sel  = 4'b0001;
        last_val = CNT_W'(H_NUM_SPARSE_DATA - 1);
      end
      LOAD_NI: begin
        seg_sel  = 4'b0010;
        last_val = CNT_W'(TOTAL_NODES - 1);
      end
      LOAD_W: begin
        seg_sel  = 4'b0100;
        last_val = CNT_W'(W_DEPTH - 1);
      end
      LOAD_A: begin
        seg_sel  = 4'b1000;
        last_val = CNT_W'(A_DEPTH - 1);
      end
      default: ;
    endcase
  end

  assign s_ready = |seg_sel;
  assign busy    = |seg_sel;
  assign accept  = s_valid && s_ready;
  assign restart = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = LOAD_H;
      LOAD_H:     if (accept && last_hit) state_d = LOAD_NI;
      LOAD_NI:    if (accept && last_hit) state_d = LOAD_W;
      LOAD_W:     if (accept && last_hit) state_d = LOAD_A;
      LOAD_A:     if (accept && last_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  loader_seg_cnt #(.CNT_W(CNT_W)) u_seg_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart),
    .inc      (accept),
    .last_val (last_val),
    .count    (count),
    .last_hit (last_hit)
  );

  // Write ports: ena is a one-cycle pulse, din/addra hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data_bram_ena        <= 1'b0;
      h_data_bram_din        <= '0;
      h_data_bram_addra      <= '0;
      h_node_info_bram_ena   <= 1'b0;
      h_node_info_bram_din   <= '0;
      h_node_info_bram_addra <= '0;
      wgt_bram_ena           <= 1'b0;
      wgt_bram_din           <= '0;
      wgt_bram_addra         <= '0;
      a_bram_ena             <= 1'b0;
      a_bram_din             <= '0;
      a_bram_addra           <= '0;
    end else begin
      h_data_bram_ena      <= accept && seg_sel[0];
      h_node_info_bram_ena <= accept && seg_sel[1];
      wgt_bram_ena         <= accept && seg_sel[2];
      a_bram_ena           <= accept && seg_sel[3];
      if (accept && seg_sel[0]) begin
        h_data_bram_din   <= s_data[H_DATA_WIDTH-1:0];
        h_data_bram_addra <= count[H_DATA_ADDR_W-1:0];
      end
      if (accept && seg_sel[1]) begin
        h_node_info_bram_din   <= s_data[NODE_INFO_WIDTH-1:0];
        h_node_info_bram_addra <= count[NODE_INFO_ADDR_W-1:0];
      end
      if (accept && seg_sel[2]) begin
        wgt_bram_din   <= s_data[DATA_WIDTH-1:0];
        wgt_bram_addra <= count[WEIGHT_ADDR_W-1:0];
      end
      if (accept && seg_sel[3]) begin
        a_bram_din   <= s_data[DATA_WIDTH-1:0];
        a_bram_addra <= count[A_ADDR_W-1:0];
      end
    end
  end

  // last_wr_q marks the final write of a segment so done lands the cycle after that ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr_q <= '0;
      done_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      last_wr_q <= (accept && last_hit) ? seg_sel : 4'b0000;
      if (restart) begin
        done_q    <= '0;
        len_err_q <= 1'b0;
      end else begin
        done_q <= done_q | last_wr_q;
        if (accept && (s_last != last_hit)) len_err_q <= 1'b1;
      end
    end
  end

  assign h_data_bram_load_done      = done_q[0];
  assign h_node_info_bram_load_done = done_q[1];
  assign wgt_bram_load_done         = done_q[2];
  assign a_bram_load_done           = done_q[3];
  assign all_done                   = done_q[3];
  assign len_err                    = len_err_q;

endmodule
